tl_burst_mst: RTL and testbench
===============================

# tl_burst_mst

TileLink-UH initiator that turns a simple client command (read/write, address, size) into one Get or a PutFullData burst on a 128-bit A channel. It collects the matching AccessAck or AccessAckData beats from the D channel. It is the master-side counterpart of the 128-bit TileLink memory responders used in the testbench and cache-refill paths. It sits between a cache/DMA client and the TileLink crossbar, with one transaction outstanding at a time.

## Interface
Parameters:
- SOURCE_ID, 0, value driven on tlmst_a_source and expected on tlmst_d_source.

Ports. Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid / req_ready  in/out  1  client command handshake
- req_wr  in  1  1 = write (PutFullData), 0 = read (Get)
- req_addr  in  32  byte address; must be aligned to 1<<req_size
- req_size  in  3  log2 bytes, 0..7 (1..128 bytes)
- wdata_valid / wdata_ready  in/out  1  write-beat handshake
- wdata  in  128  write beat
- rdata_valid / rdata_ready  out/in  1  read-beat handshake
- rdata  out  128  read beat
- rdata_last  out  1  final read beat
- done  out  1  one-cycle pulse at transaction end
- err  out  1  valid with done: denied, corrupt, or protocol mismatch seen
- tlmst_a_opcode 3, tlmst_a_param 3, tlmst_a_size 8, tlmst_a_source 3, tlmst_a_address 32, tlmst_a_mask 16, tlmst_a_data 128, tlmst_a_corrupt 1, tlmst_a_valid 1  out; tlmst_a_ready 1  in
- tlmst_d_opcode 3, tlmst_d_param 2, tlmst_d_size 8, tlmst_d_source 3, tlmst_d_sink 3, tlmst_d_denied 1, tlmst_d_data 128, tlmst_d_corrupt 1, tlmst_d_valid 1  in; tlmst_d_ready 1  out

## Operation
- States: IDLE, A_GET, D_RD, A_PUT, D_WR.
- IDLE:
  - req_ready=1.
  - On req handshake, latch addr, size and wr; set beats = (size<4) ? 1 : 1<<(size-4); clear err_acc.
  - Go to A_PUT if wr, else A_GET.
- A fields are held constant for the whole transaction: address = latched addr, size = zero-extended latched size, source = SOURCE_ID, param = 0, corrupt = 0.
- Mask:
  - size ≥ 4: 16'hFFFF.
  - size < 4: ((1<<(1<<size))-1) << addr[3:0].
- A_GET: a_valid=1, opcode=4. On a handshake go to D_RD.
- D_RD:
  - d_ready = rdata_ready; rdata_valid = d_valid; rdata = d_data.
  - Each D handshake decrements beats; rdata_last = (beats==1).
  - On the last beat go to IDLE and pulse done.
- A_PUT:
  - a_valid = wdata_valid; wdata_ready = a_ready; a_data = wdata; opcode=0.
  - Each A handshake decrements beats. After the last beat reload beats=1 and go to D_WR.
- D_WR: d_ready=1. The first D handshake goes to IDLE and pulses done.
- err = err_acc | (current D beat is erroneous). A D beat is erroneous if any of these holds:
  - denied;
  - corrupt;
  - opcode ≠ expected (1 in D_RD, 0 in D_WR);
  - source ≠ SOURCE_ID.
- An erroneous beat still counts toward completion.
- IDLE/A_*: d_ready=1; any D beat is discarded with no output effect.
- All other outputs are 0 when not named above for the current state.

## Timing
- Reset values: state IDLE, beats 0, err_acc 0. Outputs: a_valid 0, rdata_valid 0, done 0, err 0, wdata_ready 0, req_ready 1, d_ready 1.
- A-channel outputs are combinational from registered state and fields. While a_valid=1 and a_ready=0, every A field is stable.
  - A_PUT data stability relies on the client holding wdata.
- Latency:
  - Command accept to first a_valid: 1 cycle.
  - A beat to next A beat: 0 bubbles if wdata_valid and a_ready stay high.
- Read data is passed through with zero latency, not buffered.
- done is asserted in the same cycle as the final D handshake. req_ready returns the next cycle.
- A D beat arriving in the same cycle as the last A beat (A_PUT or A_GET) is ignored. The responder must not do this. Verification flags it as a protocol error on the slave.
- Reset mid-transaction: immediate return to IDLE, no done. Late D beats are dropped in IDLE.
- beats counter is 4 bits (max 8). size 7 → 8 beats; size 0..4 → 1 beat.

## Structure
- Shared package tl_pkg: opcode constants (GET=4, PUT_FULL=0, ACCESS_ACK=0, ACCESS_ACK_DATA=1) and the beat width (16 bytes).
- State encoding local to the module.
- Optional sub-module tl_mask_gen: size + addr[3:0] → 16-bit mask. Reusable by other masters.

## Test plan
- Read 64 B at 0x8000_0040 (size 6): one Get on A with mask FFFF and size 6. Four D beats D0..D3 are forwarded in order, rdata_last on the fourth, then done=1 and err=0.
- Write 32 B at 0x100 (size 5), wdata A/B: two PutFullData beats, both at address 0x100. The single AccessAck gives done=1, err=0.
- Backpressure, read 128 B with rdata_ready toggling 1-0: d_ready mirrors rdata_ready. Eight beats are accepted with none lost or duplicated.
- A stall, a_ready=0 for 3 cycles on the first Put beat: A fields and data remain stable and the beat count is unchanged.
- Partial write size 1 at 0x106: one beat with mask 16'h00C0.
- Error: read size 4, responder returns denied=1 → done=1, err=1.
- Error: responder returns opcode 0 in D_RD → done=1, err=1.
- Reset asserted in D_RD after 2 of 4 beats: outputs return to reset values immediately. A following read completes normally.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared TileLink-UH definitions: opcodes and the 128-bit beat geometry.
// Used by masters and responders alike.
package tl_pkg;

  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  localparam int TL_BEAT_BYTES = 16;
  localparam int TL_BEAT_LG    = $clog2(TL_BEAT_BYTES);

  // Anything up to one beat wide travels as a single beat.
  function automatic logic [3:0] beats_for_size(input logic [2:0] size);
    if (size < 3'(TL_BEAT_LG)) return 4'd1;
    return 4'd1 << (size - 3'(TL_BEAT_LG));
  endfunction

endpackage

// File: rtl/tl_mask_gen.sv
// Byte-lane mask for one 128-bit beat from the transfer size and low address bits.
// Transfers of a full beat or more enable every lane.
module tl_mask_gen
  import tl_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [3:0]  addr_lo,
  output logic [15:0] mask
);

  logic [31:0] lanes;
  logic [31:0] shifted;

  always_comb begin
    lanes   = (32'd1 << (32'd1 << size)) - 32'd1;
    shifted = lanes << addr_lo;
    mask    = (size >= 3'(TL_BEAT_LG)) ? 16'hFFFF : shifted[15:0];
  end

endmodule

// File: rtl/tl_burst_mst.sv
// TileLink-UH initiator: one Get or PutFullData burst per client command,
// with the matching AccessAck(Data) collected on D. One transaction in flight.
module tl_burst_mst
  import tl_pkg::*;
#(
  parameter int SOURCE_ID = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_wr,
  input  logic [31:0]  req_addr,
  input  logic [2:0]   req_size,
  input  logic         wdata_valid,
  output logic         wdata_ready,
  input  logic [127:0] wdata,
  output logic         rdata_valid,
  input  logic         rdata_ready,
  output logic [127:0] rdata,
  output logic         rdata_last,
  output logic         done,
  output logic         err,
  output logic [2:0]   tlmst_a_opcode,
  output logic [2:0]   tlmst_a_param,
  output logic [7:0]   tlmst_a_size,
  output logic [2:0]   tlmst_a_source,
  output logic [31:0]  tlmst_a_address,
  output logic [15:0]  tlmst_a_mask,
  output logic [127:0] tlmst_a_data,
  output logic         tlmst_a_corrupt,
  output logic         tlmst_a_valid,
  input  logic         tlmst_a_ready,
  input  logic [2:0]   tlmst_d_opcode,
  input  logic [1:0]   tlmst_d_param,
  input  logic [7:0]   tlmst_d_size,
  input  logic [2:0]   tlmst_d_source,
  input  logic [2:0]   tlmst_d_sink,
  input  logic         tlmst_d_denied,
  input  logic [127:0] tlmst_d_data,
  input  logic         tlmst_d_corrupt,
  input  logic         tlmst_d_valid,
  output logic         tlmst_d_ready
);

  typedef enum logic [2:0] {IDLE, A_GET, D_RD, A_PUT, D_WR} state_t;

  localparam logic [2:0] SRC = SOURCE_ID[2:0];

  state_t      state;
  logic [3:0]  beats;
  logic        err_acc;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [15:0] mask;
  logic        a_fire;
  logic        d_fire;
  logic        beat_err;
  logic        unused_d_fields;

  // Response fields this master never interprets.
  assign unused_d_fields = ^{tlmst_d_param, tlmst_d_size, tlmst_d_sink};

  tl_mask_gen u_mask (
    .size    (size_q),
    .addr_lo (addr_q[3:0]),
    .mask    (mask)
  );

  assign a_fire = tlmst_a_valid & tlmst_a_ready;
  assign d_fire = tlmst_d_valid & tlmst_d_ready;

  always_comb begin
    beat_err = tlmst_d_denied | tlmst_d_corrupt | (tlmst_d_source != SRC);
    if (state == D_RD) beat_err = beat_err | (tlmst_d_opcode != TL_ACCESS_ACK_DATA);
    else               beat_err = beat_err | (tlmst_d_opcode != TL_ACCESS_ACK);
  end

  // Control FSM; D beats outside the response states are absorbed and dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      beats   <= 4'd0;
      err_acc <= 1'b0;
      addr_q  <= 32'd0;
      size_q  <= 3'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          size_q  <= req_size;
          beats   <= beats_for_size(req_size);
          err_acc <= 1'b0;
          state   <= req_wr ? A_PUT : A_GET;
        end
        A_GET: if (tlmst_a_ready) state <= D_RD;
        D_RD: if (d_fire) begin
          beats <= beats - 4'd1;
          if (beat_err) err_acc <= 1'b1;
          if (beats == 4'd1) state <= IDLE;
        end
        A_PUT: if (a_fire) begin
          if (beats == 4'd1) begin
            beats <= 4'd1;
            state <= D_WR;
          end else begin
            beats <= beats - 4'd1;
          end
        end
        D_WR: if (d_fire) begin
          if (beat_err) err_acc <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode straight from registered state; read data is a pure pass-through.
  always_comb begin
    req_ready       = 1'b0;
    wdata_ready     = 1'b0;
    rdata_valid     = 1'b0;
    rdata           = '0;
    rdata_last      = 1'b0;
    done            = 1'b0;
    tlmst_a_valid   = 1'b0;
    tlmst_a_opcode  = 3'd0;
    tlmst_a_param   = 3'd0;
    tlmst_a_size    = 8'd0;
    tlmst_a_source  = 3'd0;
    tlmst_a_address = 32'd0;
    tlmst_a_mask    = 16'd0;
    tlmst_a_data    = '0;
    tlmst_a_corrupt = 1'b0;
    tlmst_d_ready   = 1'b1;
    if (state == A_GET || state == A_PUT) begin
      tlmst_a_size    = {5'd0, size_q};
      tlmst_a_source  = SRC;
      tlmst_a_address = addr_q;
      tlmst_a_mask    = mask;
    end
    case (state)
      IDLE:  req_ready = 1'b1;
      A_GET: begin
        tlmst_a_valid  = 1'b1;
        tlmst_a_opcode = TL_GET;
      end
      A_PUT: begin
        tlmst_a_valid  = wdata_valid;
        tlmst_a_opcode = TL_PUT_FULL;
        tlmst_a_data   = wdata;
        wdata_ready    = tlmst_a_ready;
      end
      D_RD: begin
        tlmst_d_ready = rdata_ready;
        rdata_valid   = tlmst_d_valid;
        rdata         = tlmst_d_data;
        rdata_last    = (beats == 4'd1);
        done          = tlmst_d_valid & rdata_ready & (beats == 4'd1);
      end
      D_WR:    done = tlmst_d_valid;
      default: ;
    endcase
  end

  assign err = done & (err_acc | beat_err);

endmodule

// File: tb/tb_tl_burst_mst.sv
// Directed bench for tl_burst_mst: reads, writes, backpressure, stalls,
// partial masks, error responses and reset in the middle of a burst.
module tb_tl_burst_mst;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_wr;
  logic [31:0]  req_addr;
  logic [2:0]   req_size;
  logic         wdata_valid, wdata_ready;
  logic [127:0] wdata;
  logic         rdata_valid, rdata_ready;
  logic [127:0] rdata;
  logic         rdata_last, done, err;
  logic [2:0]   tlmst_a_opcode, tlmst_a_param, tlmst_a_source;
  logic [7:0]   tlmst_a_size;
  logic [31:0]  tlmst_a_address;
  logic [15:0]  tlmst_a_mask;
  logic [127:0] tlmst_a_data;
  logic         tlmst_a_corrupt, tlmst_a_valid, tlmst_a_ready;
  logic [2:0]   tlmst_d_opcode, tlmst_d_source, tlmst_d_sink;
  logic [1:0]   tlmst_d_param;
  logic [7:0]   tlmst_d_size;
  logic         tlmst_d_denied, tlmst_d_corrupt, tlmst_d_valid, tlmst_d_ready;
  logic [127:0] tlmst_d_data;

  int checks = 0;
  int errors = 0;
  int accepted;

  tl_burst_mst #(.SOURCE_ID(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_size(req_size),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .done(done), .err(err),
    .tlmst_a_opcode(tlmst_a_opcode), .tlmst_a_param(tlmst_a_param),
    .tlmst_a_size(tlmst_a_size), .tlmst_a_source(tlmst_a_source),
    .tlmst_a_address(tlmst_a_address), .tlmst_a_mask(tlmst_a_mask),
    .tlmst_a_data(tlmst_a_data), .tlmst_a_corrupt(tlmst_a_corrupt),
    .tlmst_a_valid(tlmst_a_valid), .tlmst_a_ready(tlmst_a_ready),
    .tlmst_d_opcode(tlmst_d_opcode), .tlmst_d_param(tlmst_d_param),
    .tlmst_d_size(tlmst_d_size), .tlmst_d_source(tlmst_d_source),
    .tlmst_d_sink(tlmst_d_sink), .tlmst_d_denied(tlmst_d_denied),
    .tlmst_d_data(tlmst_d_data), .tlmst_d_corrupt(tlmst_d_corrupt),
    .tlmst_d_valid(tlmst_d_valid), .tlmst_d_ready(tlmst_d_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_req_ready", 128'(req_ready), 128'(1));
    checkOutput("rst_d_ready", 128'(tlmst_d_ready), 128'(1));
    checkOutput("rst_a_valid", 128'(tlmst_a_valid), 128'(0));
    checkOutput("rst_rdata_valid", 128'(rdata_valid), 128'(0));
    checkOutput("rst_done", 128'(done), 128'(0));
    checkOutput("rst_err", 128'(err), 128'(0));
    checkOutput("rst_wdata_ready", 128'(wdata_ready), 128'(0));
  endtask

  // Every stimulus task starts just after a falling edge and ends on one.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_size = size;
    #1 checkOutput("req_ready", 128'(req_ready), 128'(1));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic getPhase(input logic [31:0] addr, input logic [2:0] size, input logic [15:0] mask, input int stall);
    tlmst_a_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      #1 checkOutput("get_valid_stall", 128'(tlmst_a_valid), 128'(1));
      @(negedge clk);
    end
    tlmst_a_ready = 1'b1;
    #1;
    checkOutput("get_valid", 128'(tlmst_a_valid), 128'(1));
    checkOutput("get_opcode", 128'(tlmst_a_opcode), 128'(4));
    checkOutput("get_address", 128'(tlmst_a_address), 128'(addr));
    checkOutput("get_size", 128'(tlmst_a_size), 128'(size));
    checkOutput("get_mask", 128'(tlmst_a_mask), 128'(mask));
    checkOutput("get_source", 128'(tlmst_a_source), 128'(0));
    checkOutput("get_param", 128'(tlmst_a_param), 128'(0));
    checkOutput("get_corrupt", 128'(tlmst_a_corrupt), 128'(0));
    @(negedge clk);
    tlmst_a_ready = 1'b0;
  endtask

  task automatic putBeat(input logic [127:0] data, input logic [31:0] addr, input logic [2:0] size, input logic [15:0] mask);
    wdata_valid = 1'b1; wdata = data; tlmst_a_ready = 1'b1;
    #1;
    checkOutput("put_valid", 128'(tlmst_a_valid), 128'(1));
    checkOutput("put_wdata_ready", 128'(wdata_ready), 128'(1));
    checkOutput("put_opcode", 128'(tlmst_a_opcode), 128'(0));
    checkOutput("put_data", tlmst_a_data, data);
    checkOutput("put_address", 128'(tlmst_a_address), 128'(addr));
    checkOutput("put_size", 128'(tlmst_a_size), 128'(size));
    checkOutput("put_mask", 128'(tlmst_a_mask), 128'(mask));
    @(negedge clk);
    wdata_valid = 1'b0; tlmst_a_ready = 1'b0;
  endtask

  // Holding wdata_valid after the burst must not produce another A beat.
  task automatic checkBurstOver();
    wdata_valid = 1'b1;
    #1;
    checkOutput("put_over_a_valid", 128'(tlmst_a_valid), 128'(0));
    checkOutput("put_over_d_ready", 128'(tlmst_d_ready), 128'(1));
    @(negedge clk);
    wdata_valid = 1'b0;
  endtask

  task automatic dBeat(input logic [127:0] data, input logic [2:0] opc, input logic denied, input logic corrupt,
                       input logic is_read, input logic exp_last, input logic exp_done, input logic exp_err);
    tlmst_d_valid = 1'b1; tlmst_d_data = data; tlmst_d_opcode = opc;
    tlmst_d_denied = denied; tlmst_d_corrupt = corrupt; rdata_ready = 1'b1;
    #1;
    checkOutput("d_ready", 128'(tlmst_d_ready), 128'(1));
    checkOutput("done", 128'(done), 128'(exp_done));
    if (exp_done) checkOutput("err", 128'(err), 128'(exp_err));
    if (is_read) begin
      checkOutput("rdata_valid", 128'(rdata_valid), 128'(1));
      checkOutput("rdata", rdata, data);
      checkOutput("rdata_last", 128'(rdata_last), 128'(exp_last));
    end else begin
      checkOutput("wr_rdata_valid", 128'(rdata_valid), 128'(0));
    end
    @(negedge clk);
    tlmst_d_valid = 1'b0; tlmst_d_denied = 1'b0; tlmst_d_corrupt = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    #1 checkOutput(tag, 128'(req_ready), 128'(1));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_wr = 0; req_addr = 0; req_size = 0;
    wdata_valid = 0; wdata = '0; rdata_ready = 0; tlmst_a_ready = 0;
    tlmst_d_opcode = 0; tlmst_d_param = 0; tlmst_d_size = 0; tlmst_d_source = 0;
    tlmst_d_sink = 0; tlmst_d_denied = 0; tlmst_d_data = '0; tlmst_d_corrupt = 0; tlmst_d_valid = 0;
    repeat (2) @(negedge clk);
    checkReset();
    rst = 1'b0;

    // Stray D beat while idle is absorbed with no visible effect.
    tlmst_d_valid = 1'b1; tlmst_d_opcode = 3'd1;
    #1;
    checkOutput("idle_d_ready", 128'(tlmst_d_ready), 128'(1));
    checkOutput("idle_rdata_valid", 128'(rdata_valid), 128'(0));
    checkOutput("idle_done", 128'(done), 128'(0));
    @(negedge clk);
    tlmst_d_valid = 1'b0;
    checkIdle("idle_stays");

    // 64-byte read, four data beats.
    applyStimulus(1'b0, 32'h8000_0040, 3'd6);
    getPhase(32'h8000_0040, 3'd6, 16'hFFFF, 1);
    for (int i = 0; i < 4; i++)
      dBeat({4{32'hD000_0000 + 32'(i)}}, 3'd1, 1'b0, 1'b0, 1'b1, i == 3, i == 3, 1'b0);
    checkIdle("read64_idle");

    // 32-byte write, two PutFullData beats at the same address.
    applyStimulus(1'b1, 32'h0000_0100, 3'd5);
    putBeat({4{32'hAAAA_AAAA}}, 32'h100, 3'd5, 16'hFFFF);
    putBeat({4{32'hBBBB_BBBB}}, 32'h100, 3'd5, 16'hFFFF);
    checkBurstOver();
    dBeat('0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkIdle("write32_idle");

    // 128-byte read with rdata_ready alternating 0/1 on every beat.
    applyStimulus(1'b0, 32'h0000_1000, 3'd7);
    getPhase(32'h1000, 3'd7, 16'hFFFF, 0);
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      tlmst_d_valid = 1'b1; tlmst_d_opcode = 3'd1; tlmst_d_data = {4{32'hC0DE_0000 + 32'(i)}};
      rdata_ready = 1'b0;
      #1;
      checkOutput("bp_d_ready_low", 128'(tlmst_d_ready), 128'(0));
      checkOutput("bp_done_low", 128'(done), 128'(0));
      if (tlmst_d_ready) accepted++;
      @(negedge clk);
      rdata_ready = 1'b1;
      #1;
      checkOutput("bp_d_ready_high", 128'(tlmst_d_ready), 128'(1));
      checkOutput("bp_rdata", rdata, {4{32'hC0DE_0000 + 32'(i)}});
      checkOutput("bp_last", 128'(rdata_last), 128'(i == 7));
      checkOutput("bp_done", 128'(done), 128'(i == 7));
      if (tlmst_d_ready) accepted++;
      @(negedge clk);
      tlmst_d_valid = 1'b0;
    end
    checkOutput("bp_beats_accepted", 128'(accepted), 128'(8));
    checkIdle("bp_idle");

    // A-channel stall on the first Put beat: fields hold, beat count unchanged.
    applyStimulus(1'b1, 32'h0000_2000, 3'd5);
    wdata_valid = 1'b1; wdata = {4{32'h1234_5678}}; tlmst_a_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      checkOutput("stall_a_valid", 128'(tlmst_a_valid), 128'(1));
      checkOutput("stall_wdata_ready", 128'(wdata_ready), 128'(0));
      checkOutput("stall_data", tlmst_a_data, {4{32'h1234_5678}});
      checkOutput("stall_address", 128'(tlmst_a_address), 128'(32'h2000));
      @(negedge clk);
    end
    putBeat({4{32'h1234_5678}}, 32'h2000, 3'd5, 16'hFFFF);
    putBeat({4{32'h8765_4321}}, 32'h2000, 3'd5, 16'hFFFF);
    checkBurstOver();
    dBeat('0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkIdle("stall_idle");

    // Partial 2-byte write at 0x106 enables lanes 6 and 7.
    applyStimulus(1'b1, 32'h0000_0106, 3'd1);
    putBeat({4{32'h0000_BEEF}}, 32'h106, 3'd1, 16'h00C0);
    checkBurstOver();
    dBeat('0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkIdle("partial_idle");

    // Denied read response.
    applyStimulus(1'b0, 32'h0000_0200, 3'd4);
    getPhase(32'h200, 3'd4, 16'hFFFF, 0);
    dBeat({4{32'hDEAD_0001}}, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkIdle("denied_idle");

    // Wrong opcode (AccessAck) answering a Get.
    applyStimulus(1'b0, 32'h0000_0300, 3'd4);
    getPhase(32'h300, 3'd4, 16'hFFFF, 0);
    dBeat({4{32'hDEAD_0002}}, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkIdle("badop_idle");

    // Corrupt first beat is remembered until the final beat.
    applyStimulus(1'b0, 32'h0000_0400, 3'd5);
    getPhase(32'h400, 3'd5, 16'hFFFF, 0);
    dBeat({4{32'h0000_0A00}}, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    dBeat({4{32'h0000_0A01}}, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkIdle("corrupt_idle");

    // Reset after two of four read beats, then a clean read.
    applyStimulus(1'b0, 32'h0000_0500, 3'd6);
    getPhase(32'h500, 3'd6, 16'hFFFF, 0);
    dBeat({4{32'h0000_0B00}}, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    dBeat({4{32'h0000_0B01}}, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tlmst_d_valid = 1'b1; tlmst_d_opcode = 3'd1; rst = 1'b1;
    #1 checkReset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("late_d_rdata_valid", 128'(rdata_valid), 128'(0));
    checkOutput("late_d_done", 128'(done), 128'(0));
    @(negedge clk);
    tlmst_d_valid = 1'b0;
    applyStimulus(1'b0, 32'h0000_0600, 3'd4);
    getPhase(32'h600, 3'd4, 16'hFFFF, 0);
    dBeat({4{32'h0000_0C00}}, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkIdle("post_reset_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
